// File: rtl/per2rate.sv
// per2rate: converts a measured tap period (in ticks) into a rate,
// rate = floor(DIVIDEND / period), clamped to [RATE_MIN, RATE_MAX].
// A fixed-latency restoring divider produces one quotient bit per clock.
// valid/ready handshakes are used on both the period and the rate side.
// Optional build macro: PER2RATE_ROUND_EN rounds half up before clamping.
module per2rate #(
    parameter int DIVIDEND = 11_718_750,
    parameter int PER_W    = 24,
    parameter int RATE_W   = 8,
    parameter int RATE_MAX = 250,
    parameter int RATE_MIN = 30
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PER_W-1:0]  per_i,
    input  logic              per_valid_i,
    output logic              per_ready_o,
    output logic [RATE_W-1:0] rate_o,
    output logic              rate_valid_o,
    input  logic              rate_ready_i,
    output logic              clamp_hi_o,
    output logic              clamp_lo_o,
    output logic              busy_o
);

    localparam int Q_W   = $clog2(DIVIDEND + 1);
    localparam int QX_W  = Q_W + 1;
    localparam int D_W   = PER_W + Q_W;
    localparam int CNT_W = $clog2(Q_W + 1);

    localparam logic [QX_W-1:0]   MAX_X    = QX_W'(RATE_MAX);
    localparam logic [QX_W-1:0]   MIN_X    = QX_W'(RATE_MIN);
    localparam logic [RATE_W-1:0] MAX_RATE = RATE_W'(RATE_MAX);
    localparam logic [RATE_W-1:0] MIN_RATE = RATE_W'(RATE_MIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        CLAMP = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    logic [Q_W-1:0]   rem_q;
    logic [Q_W-1:0]   quo_q;
    logic [D_W-1:0]   div_q;
    logic [CNT_W-1:0] cnt_q;

    logic [D_W-1:0]   div_shift;
    logic             div_fits;
    logic [QX_W-1:0]  quo_final;

    assign per_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q == DIV) || (state_q == CLAMP);

    // Divider step: the divisor is loaded one position too high, so it is
    // shifted before comparing; Q_W steps then cover quotient bits Q_W-1..0.
    always_comb begin
        div_shift = div_q >> 1;
        div_fits  = (div_shift <= D_W'(rem_q));
    end

`ifdef PER2RATE_ROUND_EN
    localparam int CMP_W = ((Q_W > PER_W) ? Q_W : PER_W) + 1;

    logic [PER_W-1:0] per_q;
    logic [CMP_W-1:0] rem_twice;
    logic [CMP_W-1:0] per_ext;
    logic             round_up;

    // Round half up: bump the quotient when the remainder is at least half
    // the period; a zero period keeps its saturated all-ones quotient.
    always_comb begin
        rem_twice = CMP_W'(rem_q) << 1;
        per_ext   = CMP_W'(per_q);
        round_up  = (per_q != '0) && (rem_twice >= per_ext);
        quo_final = {1'b0, quo_q} + QX_W'(round_up);
    end

    // Keep the accepted period for the rounding decision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_q <= '0;
        end else if (state_q == IDLE && per_valid_i) begin
            per_q <= per_i;
        end
    end
`else
    // Truncating division: the quotient is used as-is.
    always_comb begin
        quo_final = {1'b0, quo_q};
    end
`endif

    // Control FSM with the divider datapath and the registered rate outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            quo_q        <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            rate_o       <= '0;
            rate_valid_o <= 1'b0;
            clamp_hi_o   <= 1'b0;
            clamp_lo_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (per_valid_i) begin
                        rem_q   <= Q_W'(DIVIDEND);
                        div_q   <= {per_i, {Q_W{1'b0}}};
                        quo_q   <= '0;
                        cnt_q   <= CNT_W'(Q_W);
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    div_q <= div_shift;
                    if (div_fits) begin
                        rem_q <= rem_q - div_shift[Q_W-1:0];
                        quo_q <= {quo_q[Q_W-2:0], 1'b1};
                    end else begin
                        quo_q <= {quo_q[Q_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= CLAMP;
                    end
                end
                CLAMP: begin
                    if (quo_final > MAX_X) begin
                        rate_o     <= MAX_RATE;
                        clamp_hi_o <= 1'b1;
                        clamp_lo_o <= 1'b0;
                    end else if (quo_final < MIN_X) begin
                        rate_o     <= MIN_RATE;
                        clamp_hi_o <= 1'b0;
                        clamp_lo_o <= 1'b1;
                    end else begin
                        rate_o     <= quo_final[RATE_W-1:0];
                        clamp_hi_o <= 1'b0;
                        clamp_lo_o <= 1'b0;
                    end
                    rate_valid_o <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: begin
                    if (rate_ready_i) begin
                        rate_valid_o <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    rate_valid_o <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_per2rate.sv
// tb_per2rate: scoreboard bench for per2rate. Stimulus pushes hand-computed
// expected results; a monitor pops them when rate_valid_o rises.
// Build with PER2RATE_ROUND_EN defined to check the rounding variant.
module tb_per2rate;

    localparam int LATENCY = 25;
    localparam int NVEC    = 10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [23:0] per_i = '0;
    logic        per_valid_i = 1'b0;
    logic        per_ready_o;
    logic [7:0]  rate_o;
    logic        rate_valid_o;
    logic        rate_ready_i = 1'b0;
    logic        clamp_hi_o;
    logic        clamp_lo_o;
    logic        busy_o;

    typedef struct {
        int rate;
        int hi;
        int lo;
        int acceptCycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   cycle = 0;
    int   checkCount = 0;
    int   passCount = 0;
    logic prevValid = 1'b0;
    logic expectDrop = 1'b0;

    logic [23:0] vecPer[NVEC] = '{24'd93750, 24'd46875, 24'd40000, 24'd0,
                                  24'd500000, 24'd390625, 24'd46874,
                                  24'd85000, 24'd75000, 24'd390626};
`ifdef PER2RATE_ROUND_EN
    int vecRate[NVEC] = '{125, 250, 250, 250, 30, 30, 250, 138, 156, 30};
    int vecHi[NVEC]   = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int vecLo[NVEC]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int rate85k = 138;
`else
    int vecRate[NVEC] = '{125, 250, 250, 250, 30, 30, 250, 137, 156, 30};
    int vecHi[NVEC]   = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int vecLo[NVEC]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int rate85k = 137;
`endif

    per2rate dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .per_i        (per_i),
        .per_valid_i  (per_valid_i),
        .per_ready_o  (per_ready_o),
        .rate_o       (rate_o),
        .rate_valid_o (rate_valid_o),
        .rate_ready_i (rate_ready_i),
        .clamp_hi_o   (clamp_hi_o),
        .clamp_lo_o   (clamp_lo_o),
        .busy_o       (busy_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    // Edge counter used to measure accept-to-valid latency.
    always @(posedge clk_i) cycle <= cycle + 1;

    // Compare one value and keep the running tallies.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Wait (bounded) for the block to be ready, present a period for one
    // accepting edge, then queue the expected response.
    task automatic applyStimulus(input logic [23:0] per, input int rate, input int hi, input int lo);
        int n = 0;
        while (!per_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!per_ready_o) begin
            checkOutput("ready_timeout", 0, 1);
        end else begin
            per_i = per;
            per_valid_i = 1'b1;
            @(negedge clk_i);
            per_valid_i = 1'b0;
            expQ.push_back('{rate, hi, lo, cycle});
        end
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic waitResult();
        int n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("result_timeout", expQ.size(), 0);
            expQ.delete();
        end
    endtask

    // Monitor: on each rising rate_valid_o, pop and compare the expectation;
    // after a completed handshake the valid must drop on the next cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prevValid = 1'b0;
            expectDrop = 1'b0;
        end else begin
            if (expectDrop) begin
                checkOutput("valid_single_cycle", int'(rate_valid_o), 0);
                expectDrop = 1'b0;
            end
            if (rate_valid_o && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("rate", int'(rate_o), monE.rate);
                    checkOutput("clamp_hi", int'(clamp_hi_o), monE.hi);
                    checkOutput("clamp_lo", int'(clamp_lo_o), monE.lo);
                    checkOutput("latency", cycle - monE.acceptCycle, LATENCY);
                    checkOutput("flags_exclusive", int'(clamp_hi_o & clamp_lo_o), 0);
                end
            end
            if (rate_valid_o && rate_ready_i) begin
                expectDrop = 1'b1;
            end
            prevValid = rate_valid_o;
        end
    end

    // Hard stop in case the stimulus process itself stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("reset_rate", int'(rate_o), 0);
        checkOutput("reset_valid", int'(rate_valid_o), 0);
        checkOutput("reset_hi", int'(clamp_hi_o), 0);
        checkOutput("reset_lo", int'(clamp_lo_o), 0);
        checkOutput("reset_busy", int'(busy_o), 0);
        checkOutput("reset_ready", int'(per_ready_o), 1);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed vectors with the consumer always ready.
        rate_ready_i = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecPer[i], vecRate[i], vecHi[i], vecLo[i]);
            waitResult();
        end

        // Backpressure: hold the result, pulse a period that must be ignored.
        rate_ready_i = 1'b0;
        applyStimulus(24'd93750, 125, 0, 0);
        begin
            int n = 0;
            while (!rate_valid_o && n < 100) begin
                @(negedge clk_i);
                n++;
            end
        end
        checkOutput("bp_valid_reached", int'(rate_valid_o), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            checkOutput("bp_rate_stable", int'(rate_o), 125);
            checkOutput("bp_valid_held", int'(rate_valid_o), 1);
            checkOutput("bp_ready_low", int'(per_ready_o), 0);
            if (i == 3) begin
                per_i = 24'd80000;
                per_valid_i = 1'b1;
            end
            if (i == 4) begin
                per_valid_i = 1'b0;
            end
        end
        // Release together with a new period: only the rate handshake completes.
        per_i = 24'd80000;
        per_valid_i = 1'b1;
        rate_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("hs_back_idle", int'(per_ready_o), 1);
        checkOutput("hs_not_busy", int'(busy_o), 0);
        checkOutput("hs_valid_low", int'(rate_valid_o), 0);
        checkOutput("hs_rate_kept", int'(rate_o), 125);
        @(negedge clk_i);
        per_valid_i = 1'b0;
        expQ.push_back('{146, 0, 0, cycle});
        waitResult();

        // Reset in the middle of a division.
        @(negedge clk_i);
        per_i = 24'd93750;
        per_valid_i = 1'b1;
        @(negedge clk_i);
        per_valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        checkOutput("div_busy", int'(busy_o), 1);
        checkOutput("div_ready_low", int'(per_ready_o), 0);
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_rate", int'(rate_o), 0);
        checkOutput("midrst_valid", int'(rate_valid_o), 0);
        checkOutput("midrst_hi", int'(clamp_hi_o), 0);
        checkOutput("midrst_lo", int'(clamp_lo_o), 0);
        checkOutput("midrst_busy", int'(busy_o), 0);
        checkOutput("midrst_ready", int'(per_ready_o), 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (30) @(negedge clk_i);
        checkOutput("postrst_idle", int'(per_ready_o), 1);
        applyStimulus(24'd85000, rate85k, 0, 0);
        waitResult();

        repeat (3) @(negedge clk_i);
        checkOutput("scoreboard_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
